// File: rtl/mossbauer_ram_arbiter_if.sv
// Bus bundle shared by the spectrum RAM arbiter, the accumulation path,
// the CAMAC exchange path and the single-port RAM macro.
interface mossbauer_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
);
    logic              acc_req;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_ack;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              ovf;
    logic              ovf_clr;

    // Requesters and RAM model side.
    modport master (
        output acc_req, acc_addr, acc_data,
        output host_req, host_we, host_addr, host_wdata,
        output ram_rdata, ovf_clr,
        input  acc_ack, host_rdata, host_ack,
        input  ram_addr, ram_we, ram_wdata, ovf
    );

    // Arbiter side.
    modport slave (
        input  acc_req, acc_addr, acc_data,
        input  host_req, host_we, host_addr, host_wdata,
        input  ram_rdata, ovf_clr,
        output acc_ack, host_rdata, host_ack,
        output ram_addr, ram_we, ram_wdata, ovf
    );
endinterface

// File: rtl/mossbauer_ram_arbiter.sv
// Sequencer/arbiter for the Mossbauer spectrum RAM: saturating read-modify-write
// accumulates and CAMAC word accesses, alternating grants under contention.
module mossbauer_ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    mossbauer_ram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ACC_RD, ACC_WR, H_WR, H_RD, H_CAP, H_ACK} state_t;

    state_t            state, state_nxt;
    logic              last_host;
    logic              grant_acc, grant_host;
    logic              we, acc_done, host_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W:0]   acc_sum;
    logic              ovf_q;

    function automatic logic [DATA_W:0] wide_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [DATA_W-1:0] saturate(input logic [DATA_W:0] s);
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    assign acc_sum = wide_add(bus.ram_rdata, data_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_acc  = 1'b0;
        grant_host = 1'b0;
        we         = 1'b0;
        acc_done   = 1'b0;
        host_done  = 1'b0;
        case (state)
            IDLE: begin
                // Under contention the side that was not served last wins.
                if (bus.acc_req && (!bus.host_req || last_host)) begin
                    grant_acc = 1'b1;
                    state_nxt = ACC_RD;
                end else if (bus.host_req) begin
                    grant_host = 1'b1;
                    state_nxt  = bus.host_we ? H_WR : H_RD;
                end
            end
            ACC_RD: state_nxt = ACC_WR;
            ACC_WR: begin
                we        = 1'b1;
                acc_done  = 1'b1;
                state_nxt = IDLE;
            end
            H_WR: begin
                we        = 1'b1;
                host_done = 1'b1;
                state_nxt = IDLE;
            end
            H_RD:  state_nxt = H_CAP;
            H_CAP: state_nxt = H_ACK;
            H_ACK: begin
                host_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset aborts any operation: no write strobe, no acknowledge.
        if (rst) begin
            we         = 1'b0;
            acc_done   = 1'b0;
            host_done  = 1'b0;
            grant_acc  = 1'b0;
            grant_host = 1'b0;
            state_nxt  = IDLE;
        end
    end

    always_comb begin
        wdata = wdata_q;
        if (state == ACC_WR)    wdata = saturate(acc_sum);
        else if (state == H_WR) wdata = data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_host <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (grant_acc) begin
                last_host <= 1'b0;
                addr_q    <= bus.acc_addr;
            end else if (grant_host) begin
                last_host <= 1'b1;
                addr_q    <= bus.host_addr;
            end
            if (we) wdata_q <= wdata;
            if (state == H_CAP) rdata_q <= bus.ram_rdata;
            // A new saturation takes priority over a coincident clear.
            if ((state == ACC_WR) && acc_sum[DATA_W]) ovf_q <= 1'b1;
            else if (bus.ovf_clr)                     ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (grant_acc)       data_q <= bus.acc_data;
        else if (grant_host) data_q <= bus.host_wdata;
    end

    assign bus.ram_addr   = addr_q;
    assign bus.ram_we     = we;
    assign bus.ram_wdata  = wdata;
    assign bus.acc_ack    = acc_done;
    assign bus.host_ack   = host_done;
    assign bus.host_rdata = rdata_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_mossbauer_ram_arbiter.sv
// Self-checking bench for mossbauer_ram_arbiter: directed scenarios plus a
// randomized contention run against a saturating-memory reference model.
module tb_mossbauer_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 24;
    localparam longint MAXV = 64'hFFFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    mossbauer_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mossbauer_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM model: read data valid the cycle after the address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    function automatic logic [DW-1:0] model_acc(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        return (s > MAXV) ? 24'hFFFFFF : a + b;
    endfunction

    function automatic bit model_sat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (longint'(a) + longint'(b)) > MAXV;
    endfunction

    task automatic run_acc(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [7:0] ackm, output logic [7:0] wem,
                           output logic [DW-1:0] wd, output int ackc);
        ackm = '0; wem = '0; wd = '0; ackc = -1;
        bus.acc_addr = a; bus.acc_data = d; bus.acc_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ram_we) begin wem[k] = 1'b1; wd = bus.ram_wdata; end
            if (bus.acc_ack) begin
                ackm[k] = 1'b1; ackc = cyc;
                @(posedge clk); #1;
                bus.acc_req = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.acc_req = 1'b0;
    endtask

    task automatic run_host(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [7:0] ackm, output logic [7:0] wem,
                            output logic [DW-1:0] rd);
        ackm = '0; wem = '0; rd = '0;
        bus.host_we = we; bus.host_addr = a; bus.host_wdata = d; bus.host_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ram_we) wem[k] = 1'b1;
            if (bus.host_ack) begin
                ackm[k] = 1'b1; rd = bus.host_rdata;
                @(posedge clk); #1;
                bus.host_req = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.host_req = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        logic [7:0] am, wm; logic [DW-1:0] rd;
        run_host(1'b1, a, v, am, wm, rd);
        checks++;
        if (am !== 8'b10) begin
            failures++; $display("FAIL preload_ack addr=%0h got=%b want=%b", a, am, 8'b10);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 7;
        if (bus.acc_ack !== 1'b0)  begin failures++; $display("FAIL reset_acc_ack got=%b want=0", bus.acc_ack); end
        if (bus.host_ack !== 1'b0) begin failures++; $display("FAIL reset_host_ack got=%b want=0", bus.host_ack); end
        if (bus.ram_we !== 1'b0)   begin failures++; $display("FAIL reset_ram_we got=%b want=0", bus.ram_we); end
        if (bus.ovf !== 1'b0)      begin failures++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        if (bus.ram_addr !== '0)   begin failures++; $display("FAIL reset_ram_addr got=%h want=0", bus.ram_addr); end
        if (bus.ram_wdata !== '0)  begin failures++; $display("FAIL reset_ram_wdata got=%h want=0", bus.ram_wdata); end
        if (bus.host_rdata !== '0) begin failures++; $display("FAIL reset_host_rdata got=%h want=0", bus.host_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_accumulate();
        logic [7:0] am, wm; logic [DW-1:0] wd; int ac;
        preload(5, 24'd10);
        run_acc(5, 24'd7, am, wm, wd, ac);
        checks += 5;
        if (am !== 8'b100) begin failures++; $display("FAIL acc_ack_cycle got=%b want=%b", am, 8'b100); end
        if (wm !== 8'b100) begin failures++; $display("FAIL acc_we_cycle got=%b want=%b", wm, 8'b100); end
        if (wd !== 24'd17) begin failures++; $display("FAIL acc_wdata got=%0d want=17", wd); end
        @(negedge clk);
        if (bus.acc_ack !== 1'b0) begin failures++; $display("FAIL acc_ack_pulse got=%b want=0", bus.acc_ack); end
        if (mem[5] !== 24'd17) begin failures++; $display("FAIL acc_mem got=%0d want=17", mem[5]); end
        checks++;
        if (bus.ovf !== 1'b0) begin failures++; $display("FAIL acc_ovf got=%b want=0", bus.ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [7:0] am, wm; logic [DW-1:0] wd; int ac;
        preload(0, 24'hFFFFF0);
        run_acc(0, 24'h20, am, wm, wd, ac);
        checks += 3;
        if (mem[0] !== 24'hFFFFFF) begin failures++; $display("FAIL sat_mem got=%h want=ffffff", mem[0]); end
        if (wd !== 24'hFFFFFF)     begin failures++; $display("FAIL sat_wdata got=%h want=ffffff", wd); end
        if (bus.ovf !== 1'b1)      begin failures++; $display("FAIL sat_ovf_set got=%b want=1", bus.ovf); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf_sticky got=%b want=1", bus.ovf); end
        @(posedge clk); #1 bus.ovf_clr = 1'b1;
        @(posedge clk); #1 bus.ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_clr got=%b want=0", bus.ovf); end
        @(posedge clk); #1;
        bus.acc_addr = 0; bus.acc_data = 24'd1; bus.acc_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 bus.ovf_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.acc_ack !== 1'b1) begin failures++; $display("FAIL sat_coinc_ack got=%b want=1", bus.acc_ack); end
        @(posedge clk); #1 bus.ovf_clr = 1'b0; bus.acc_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ovf !== 1'b1) begin failures++; $display("FAIL sat_set_wins got=%b want=1", bus.ovf); end
        @(posedge clk); #1;
    endtask

    task automatic test_host_rw();
        logic [7:0] am, wm; logic [DW-1:0] rd;
        run_host(1'b1, 12'hFFF, 24'h123456, am, wm, rd);
        checks += 2;
        if (am !== 8'b10) begin failures++; $display("FAIL hwr_ack_cycle got=%b want=%b", am, 8'b10); end
        if (mem[12'hFFF] !== 24'h123456) begin failures++; $display("FAIL hwr_mem got=%h want=123456", mem[12'hFFF]); end
        run_host(1'b0, 12'hFFF, 24'h0, am, wm, rd);
        checks += 3;
        if (am !== 8'b1000) begin failures++; $display("FAIL hrd_ack_cycle got=%b want=%b", am, 8'b1000); end
        if (wm !== 8'b0)    begin failures++; $display("FAIL hrd_no_write got=%b want=0", wm); end
        if (rd !== 24'h123456) begin failures++; $display("FAIL hrd_data got=%h want=123456", rd); end
        run_host(1'b1, 12'hFFF, 24'hABCDEF, am, wm, rd);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.host_rdata !== 24'h123456) begin failures++; $display("FAIL hrd_hold got=%h want=123456", bus.host_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention_after_reset();
        int acc_k, host_k;
        preload(7, 24'd0);
        do_reset();
        acc_k = -1; host_k = -1;
        bus.acc_addr = 7; bus.acc_data = 24'd3; bus.acc_req = 1'b1;
        bus.host_we = 1'b1; bus.host_addr = 9; bus.host_wdata = 24'h55; bus.host_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.acc_ack && acc_k < 0) acc_k = k;
            if (bus.host_ack && host_k < 0) host_k = k;
            @(posedge clk); #1;
            if (acc_k >= 0) bus.acc_req = 1'b0;
            if (host_k >= 0) bus.host_req = 1'b0;
        end
        checks += 4;
        if (acc_k != 2)  begin failures++; $display("FAIL cont_acc_first got=%0d want=2", acc_k); end
        if (host_k != 4) begin failures++; $display("FAIL cont_host_second got=%0d want=4", host_k); end
        if (mem[7] !== 24'd3)  begin failures++; $display("FAIL cont_acc_mem got=%0d want=3", mem[7]); end
        if (mem[9] !== 24'h55) begin failures++; $display("FAIL cont_host_mem got=%h want=55", mem[9]); end
    endtask

    task automatic test_reset_mid_acc();
        logic [7:0] am, wm; logic [DW-1:0] wd; int ac;
        preload(3, 24'd4);
        bus.acc_addr = 3; bus.acc_data = 24'd9; bus.acc_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; bus.acc_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.ram_we !== 1'b0)  begin failures++; $display("FAIL rstmid_we got=%b want=0", bus.ram_we); end
        if (bus.acc_ack !== 1'b0) begin failures++; $display("FAIL rstmid_ack got=%b want=0", bus.acc_ack); end
        @(posedge clk); #1 rst = 1'b0;
        run_acc(3, 24'd1, am, wm, wd, ac);
        checks += 2;
        if (am !== 8'b100) begin failures++; $display("FAIL rstmid_next_ack got=%b want=%b", am, 8'b100); end
        if (mem[3] !== 24'd5) begin failures++; $display("FAIL rstmid_mem got=%0d want=5", mem[3]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] am, wm; logic [DW-1:0] wd; int s, a1, a2;
        preload(3, 24'd0);
        s = cyc;
        run_acc(3, 24'd1, am, wm, wd, a1);
        run_acc(3, 24'd1, am, wm, wd, a2);
        checks += 3;
        if (a1 - s != 2) begin failures++; $display("FAIL b2b_first_ack got=%0d want=2", a1 - s); end
        if (a2 - s != 5) begin failures++; $display("FAIL b2b_second_ack got=%0d want=5", a2 - s); end
        if (mem[3] !== 24'd2) begin failures++; $display("FAIL b2b_mem got=%0d want=2", mem[3]); end
    endtask

    task automatic rand_acc();
        bus.acc_addr = AW'($urandom_range(0, 15));
        bus.acc_data = ($urandom % 3 == 0) ? DW'($urandom_range(0, 24'hFFFFFF)) : DW'($urandom_range(0, 255));
    endtask

    task automatic rand_host();
        bus.host_we = 1'($urandom % 2);
        bus.host_addr = AW'($urandom_range(0, 15));
        bus.host_wdata = DW'($urandom);
    endtask

    task automatic test_random_contention();
        logic [DW-1:0] ref_mem [0:15];
        logic [DW-1:0] v;
        bit ref_ovf, a_new, h_new;
        int last_who, last_k, done_a, done_h, want_gap;
        localparam int N = 30;
        for (int i = 0; i < 16; i++) begin
            v = ($urandom % 2 == 1) ? DW'($urandom_range(24'hFFFF00, 24'hFFFFFF)) : DW'($urandom_range(0, 16'hFFFF));
            preload(AW'(i), v);
            ref_mem[i] = v;
        end
        do_reset();
        ref_ovf = 1'b0; last_who = 0; last_k = -1; done_a = 0; done_h = 0;
        rand_acc(); rand_host();
        bus.acc_req = 1'b1; bus.host_req = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            a_new = 1'b0; h_new = 1'b0;
            if (bus.acc_ack) begin
                checks++;
                if (last_who == 1) begin failures++; $display("FAIL rnd_alternate k=%0d got=acc want=host", k); end
                if (last_k >= 0) begin
                    checks++;
                    if (k - last_k != 3) begin failures++; $display("FAIL rnd_acc_gap k=%0d got=%0d want=3", k, k - last_k); end
                end
                ref_ovf = ref_ovf | model_sat(ref_mem[bus.acc_addr[3:0]], bus.acc_data);
                ref_mem[bus.acc_addr[3:0]] = model_acc(ref_mem[bus.acc_addr[3:0]], bus.acc_data);
                last_who = 1; last_k = k; done_a++; a_new = 1'b1;
            end
            if (bus.host_ack) begin
                checks++;
                if (last_who != 1) begin failures++; $display("FAIL rnd_alternate k=%0d got=host want=acc", k); end
                want_gap = bus.host_we ? 2 : 4;
                checks++;
                if (k - last_k != want_gap) begin failures++; $display("FAIL rnd_host_gap k=%0d got=%0d want=%0d", k, k - last_k, want_gap); end
                if (bus.host_we) ref_mem[bus.host_addr[3:0]] = bus.host_wdata;
                else begin
                    checks++;
                    if (bus.host_rdata !== ref_mem[bus.host_addr[3:0]]) begin
                        failures++; $display("FAIL rnd_read addr=%0d got=%h want=%h", bus.host_addr, bus.host_rdata, ref_mem[bus.host_addr[3:0]]);
                    end
                end
                last_who = 2; last_k = k; done_h++; h_new = 1'b1;
            end
            @(posedge clk); #1;
            if (done_a >= N && done_h >= N) break;
            if (a_new) rand_acc();
            if (h_new) rand_host();
        end
        bus.acc_req = 1'b0; bus.host_req = 1'b0;
        checks++;
        if (done_a < N || done_h < N) begin failures++; $display("FAIL rnd_timeout acc=%0d host=%0d want=%0d", done_a, done_h, N); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin failures++; $display("FAIL rnd_mem addr=%0d got=%h want=%h", i, mem[i], ref_mem[i]); end
        end
        checks++;
        if (bus.ovf !== ref_ovf) begin failures++; $display("FAIL rnd_ovf got=%b want=%b", bus.ovf, ref_ovf); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.acc_req = 1'b0; bus.acc_addr = '0; bus.acc_data = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_accumulate();
        test_saturation();
        test_host_rw();
        test_contention_after_reset();
        test_reset_mid_acc();
        test_back_to_back();
        test_random_contention();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mossbauer_ram_arbiter.md
# mossbauer_ram_arbiter

Sequencer and arbiter for the single-port spectrum RAM of the Mössbauer CAMAC accumulator. It shares the RAM between two requesters. The accumulation path issues read-modify-write "add counter snapshot to bin" operations on every channel advance. The CAMAC programmed-exchange path issues plain word reads and writes. The block sits between the accumulator/counter logic, the CAMAC function decoder and the RAM macro, and owns every RAM port signal.

## Interface
Parameters:
- ADDR_W, 12, spectrum bin address width (RAM depth 2^ADDR_W)
- DATA_W, 24, bin/counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- acc_req  in  1  accumulate request, level, held until acc_ack
- acc_addr  in  ADDR_W  bin to accumulate into
- acc_data  in  DATA_W  counter snapshot to add
- acc_ack  out  1  one-cycle pulse: accumulate written
- host_req  in  1  CAMAC access request, level, held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  CAMAC address register value
- host_wdata  in  DATA_W  CAMAC write data
- host_rdata  out  DATA_W  read data, holds until next host read completes
- host_ack  out  1  one-cycle pulse: access done / host_rdata valid
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented with ram_we=0
- ovf  out  1  sticky bin-saturation flag
- ovf_clr  in  1  clears ovf

## Operation
- States: IDLE, ACC_RD, ACC_WR, H_WR, H_RD, H_CAP, H_ACK.
- Requests are sampled only in IDLE. On a grant, the request's address and data are latched; requester inputs are ignored until the ack.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the one not granted last (last_grant register, updated on every grant).
  - Reset value of last_grant = host, so the accumulator wins the first contention.
- Accumulate: IDLE → ACC_RD → ACC_WR → IDLE.
  - ACC_RD: ram_addr = latched addr, ram_we = 0.
  - ACC_WR: ram_we = 1, ram_addr = latched addr, acc_ack = 1.
  - ram_wdata = ram_rdata + latched data, computed DATA_W+1 bits wide. On carry, write all-ones (saturate) and set ovf.
- Host write: IDLE → H_WR → IDLE. H_WR: ram_we = 1, ram_wdata = latched wdata, host_ack = 1.
- Host read: IDLE → H_RD → H_CAP → H_ACK → IDLE.
  - H_RD presents the address with ram_we = 0.
  - At the end of H_CAP, host_rdata is loaded from ram_rdata.
  - H_ACK: host_ack = 1, no RAM access.
- In IDLE and H_ACK: ram_we = 0; ram_addr and ram_wdata hold their last values.
- ovf: sticky. If set and ovf_clr coincide, set wins.
- No RAM hazard between consecutive operations: each one completes before IDLE is re-entered.

## Timing
- Cycle 0 = IDLE cycle that samples the request.
  - Accumulate: ACC_RD at 1, ACC_WR + acc_ack at 2, IDLE at 3.
  - Host write: H_WR + host_ack at 1, IDLE at 2.
  - Host read: H_RD at 1, H_CAP at 2, H_ACK + host_ack at 3 (host_rdata valid), IDLE at 4.
- The requester deasserts its request at the clock edge ending its ack cycle. The next IDLE therefore never re-grants the same request.
- Throughput: one accumulate per 3 cycles; under continuous contention, strict alternation.
- Reset values: state IDLE, last_grant = host, acc_ack = host_ack = ram_we = ovf = 0, ram_addr = 0, ram_wdata = 0, host_rdata = 0.
- Reset mid-operation: the operation is aborted. ram_we is forced low in any cycle where rst = 1, so no partial write occurs. No ack is issued; state is IDLE the cycle after rst.
- Wrap-around: addresses are used as given; no increment logic in this block.

## Test plan
- Accumulate: RAM[5] = 10; acc_req, addr 5, data 7 → ram_we only in cycle 2 with wdata 17; RAM[5] = 17; acc_ack a single pulse in cycle 2; ovf = 0.
- Saturation: RAM[0] = 0xFFFFF0, acc_data = 0x20 → RAM[0] = 0xFFFFFF, ovf = 1 and stays 1. ovf_clr pulse → 0. ovf_clr coincident with a new saturation → ovf stays 1.
- Host write/read: write 0x123456 to 0xFFF (host_ack in cycle 1), then read 0xFFF → host_ack in cycle 3, host_rdata = 0x123456 and held afterwards.
- Contention after reset: acc_req and host_req asserted together → accumulator served (ack in cycle 2), host granted at cycle 3. Both re-asserted continuously → grants alternate acc/host with no starvation.
- Reset during ACC_RD: RAM[3] = 4, rst pulsed in ACC_RD → no write, no acc_ack, IDLE next cycle, RAM[3] = 4; a subsequent request completes normally.
- Back-to-back accumulates of data 1 into bin 3 (twice), starting from 0 → RAM[3] = 2; second ACC_RD starts at cycle 4.
